// File: rtl/vote_display_ctrl.sv
`default_nettype none
// ============================================================================
// Module : vote_display_ctrl
// Brief  : Front-panel LED controller: vote acknowledge flash, result display
//          with button select / idle auto-scan, and winner/tie tracking.
// Rev    : 1.0  initial release
// ============================================================================
module vote_display_ctrl #(
   parameter int NUM_CAND     = 4,
   parameter int VOTE_W       = 8,
   parameter int LED_W        = 8,
   parameter int FLASH_CYCLES = 10,
   parameter int SCAN_CYCLES  = 50,
   localparam int c_SEL_W     = $clog2(NUM_CAND)
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       mode,
   input  logic                       valid_vote_casted,
   input  logic [NUM_CAND*VOTE_W-1:0] cand_votes,
   input  logic [NUM_CAND-1:0]        cand_button_press,
   output logic [LED_W-1:0]           leds,
   output logic [c_SEL_W-1:0]         sel_cand,
   output logic [c_SEL_W-1:0]         winner,
   output logic                       tie,
   output logic                       flash_active
);

   localparam int c_FW = (FLASH_CYCLES > 1) ? $clog2(FLASH_CYCLES) : 1;
   localparam int c_TW = $clog2(SCAN_CYCLES);

   typedef enum logic [1:0] {
      VOTE_IDLE = 2'd0,
      VOTE_ACK  = 2'd1,
      RES_SHOW  = 2'd2,
      RES_SCAN  = 2'd3
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [c_FW-1:0]     r_flash_cnt;
   logic [c_FW-1:0]     w_flash_cnt_nxt;
   logic [c_TW-1:0]     r_timer;
   logic [c_TW-1:0]     w_timer_nxt;
   logic [c_SEL_W-1:0]  w_sel_nxt;
   logic [c_SEL_W-1:0]  w_sel_inc;
   logic [c_SEL_W-1:0]  w_win;
   logic [c_SEL_W-1:0]  w_btn_idx;
   logic                w_tie;
   logic [VOTE_W-1:0]   w_max;
   logic [VOTE_W-1:0]   w_sel_count;
   logic [LED_W-1:0]    w_leds_res;
   logic [LED_W-1:0]    w_leds_nxt;
   logic                w_flash_nxt;

   // Strictly-greater update keeps the lowest index on equal counts; an equal
   // count seen against the running maximum marks a tie.
   always_comb begin
      w_max = cand_votes[0 +: VOTE_W];
      w_win = '0;
      w_tie = 1'b0;
      for (int i = 1; i < NUM_CAND; i++) begin
         if (cand_votes[i*VOTE_W +: VOTE_W] > w_max) begin
            w_max = cand_votes[i*VOTE_W +: VOTE_W];
            w_win = c_SEL_W'(i);
            w_tie = 1'b0;
         end else if (cand_votes[i*VOTE_W +: VOTE_W] == w_max) begin
            w_tie = 1'b1;
         end
      end
   end

   always_comb begin
      w_btn_idx = '0;
      for (int i = NUM_CAND - 1; i >= 0; i--) begin
         if (cand_button_press[i]) begin
            w_btn_idx = c_SEL_W'(i);
         end
      end
   end

   assign w_sel_inc   = (sel_cand == c_SEL_W'(NUM_CAND - 1)) ? '0 : sel_cand + 1'b1;
   assign w_sel_count = cand_votes[w_sel_nxt*VOTE_W +: VOTE_W];

   generate
      if (VOTE_W <= LED_W) begin : g_zext
         assign w_leds_res = LED_W'(w_sel_count);
      end else begin : g_sat
         assign w_leds_res = (|w_sel_count[VOTE_W-1:LED_W]) ? {LED_W{1'b1}}
                                                            : w_sel_count[LED_W-1:0];
      end
   endgenerate

   always_comb begin
      w_state_nxt     = r_state;
      w_flash_cnt_nxt = r_flash_cnt;
      w_timer_nxt     = r_timer;
      w_sel_nxt       = sel_cand;
      case (r_state)
         VOTE_IDLE, VOTE_ACK: begin
            if (mode) begin
               w_state_nxt     = RES_SHOW;
               w_timer_nxt     = '0;
               w_flash_cnt_nxt = '0;
               w_sel_nxt       = w_win;
            end else if (valid_vote_casted) begin
               w_state_nxt     = VOTE_ACK;
               w_flash_cnt_nxt = c_FW'(FLASH_CYCLES - 1);
            end else if (r_state == VOTE_ACK) begin
               if (r_flash_cnt == '0) begin
                  w_state_nxt = VOTE_IDLE;
               end else begin
                  w_flash_cnt_nxt = r_flash_cnt - 1'b1;
               end
            end
         end
         RES_SHOW, RES_SCAN: begin
            if (!mode) begin
               w_state_nxt = VOTE_IDLE;
               w_timer_nxt = '0;
            end else if (|cand_button_press) begin
               w_state_nxt = RES_SHOW;
               w_timer_nxt = '0;
               w_sel_nxt   = w_btn_idx;
            end else if (r_timer == c_TW'(SCAN_CYCLES - 1)) begin
               // End of the idle wait and end of each dwell both step the scan.
               w_state_nxt = RES_SCAN;
               w_timer_nxt = '0;
               w_sel_nxt   = w_sel_inc;
            end else begin
               w_timer_nxt = r_timer + 1'b1;
            end
         end
         default: begin
            w_state_nxt = VOTE_IDLE;
         end
      endcase
   end

   always_comb begin
      w_flash_nxt = (w_state_nxt == VOTE_ACK);
      w_leds_nxt  = '0;
      if (w_state_nxt == VOTE_ACK) begin
         w_leds_nxt = {LED_W{1'b1}};
      end else if (w_state_nxt == RES_SHOW || w_state_nxt == RES_SCAN) begin
         w_leds_nxt = w_leds_res;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= VOTE_IDLE;
         r_flash_cnt  <= '0;
         r_timer      <= '0;
         sel_cand     <= '0;
         leds         <= '0;
         flash_active <= 1'b0;
         winner       <= '0;
         tie          <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_flash_cnt  <= w_flash_cnt_nxt;
         r_timer      <= w_timer_nxt;
         sel_cand     <= w_sel_nxt;
         leds         <= w_leds_nxt;
         flash_active <= w_flash_nxt;
         winner       <= w_win;
         tie          <= w_tie;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_vote_display_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_vote_display_ctrl
// Brief  : Scoreboard bench for vote_display_ctrl, default build plus a
//          VOTE_W=10 / LED_W=8 build sharing the same control inputs.
// Rev    : 1.0  initial release
// ============================================================================
module tb_vote_display_ctrl;

   localparam int N     = 4;
   localparam int FLASH = 10;
   localparam int SCAN  = 50;

   logic        clk   = 1'b0;
   logic        reset = 1'b0;
   logic        mode  = 1'b0;
   logic        valid = 1'b0;
   logic [3:0]  btn   = '0;
   logic [31:0] votes_a = '0;
   logic [39:0] votes_b = '0;

   logic [7:0] leds_a, leds_b;
   logic [1:0] sel_a, sel_b, win_a, win_b;
   logic       tie_a, tie_b, fl_a, fl_b;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      bit res;
      int flash_left;
      int timer;
      int sel;
   } mstate_t;

   typedef struct {
      int leds;
      int sel;
      int win;
      int tie;
      int fl;
      bit res;
   } exp_t;

   mstate_t ma, mb;
   exp_t    qa[$];
   exp_t    qb[$];

   always #5 clk = ~clk;

   vote_display_ctrl #(.NUM_CAND(N), .VOTE_W(8), .LED_W(8),
                       .FLASH_CYCLES(FLASH), .SCAN_CYCLES(SCAN)) dut_a (
      .clk(clk), .reset(reset), .mode(mode), .valid_vote_casted(valid),
      .cand_votes(votes_a), .cand_button_press(btn), .leds(leds_a),
      .sel_cand(sel_a), .winner(win_a), .tie(tie_a), .flash_active(fl_a));

   vote_display_ctrl #(.NUM_CAND(N), .VOTE_W(10), .LED_W(8),
                       .FLASH_CYCLES(FLASH), .SCAN_CYCLES(SCAN)) dut_b (
      .clk(clk), .reset(reset), .mode(mode), .valid_vote_casted(valid),
      .cand_votes(votes_b), .cand_button_press(btn), .leds(leds_b),
      .sel_cand(sel_b), .winner(win_b), .tie(tie_b), .flash_active(fl_b));

   task automatic chk(input string nm, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference: flash_left counts remaining all-on cycles; timer counts idle
   // cycles in result mode, and every SCAN of them moves to the next candidate.
   function automatic void mstep(inout mstate_t m, input int v[4], input int ledmax,
                                 output exp_t e);
      int mx, win, nmax, lowest;
      mx = -1; win = 0; nmax = 0; lowest = -1;
      for (int i = 0; i < N; i++) if (v[i] > mx) begin mx = v[i]; win = i; end
      for (int i = 0; i < N; i++) if (v[i] == mx) nmax++;
      for (int i = N - 1; i >= 0; i--) if (btn[i]) lowest = i;
      if (!m.res) begin
         if (mode) begin
            m.res = 1; m.timer = 0; m.sel = win; m.flash_left = 0;
         end else if (valid) begin
            m.flash_left = FLASH;
         end else if (m.flash_left > 0) begin
            m.flash_left--;
         end
      end else begin
         if (!mode) begin
            m.res = 0; m.timer = 0; m.flash_left = 0;
         end else if (lowest >= 0) begin
            m.sel = lowest; m.timer = 0;
         end else begin
            m.timer++;
            if (m.timer == SCAN) begin
               m.timer = 0;
               m.sel = (m.sel + 1) % N;
            end
         end
      end
      e.res  = m.res;
      e.sel  = m.sel;
      e.win  = win;
      e.tie  = (nmax > 1) ? 1 : 0;
      e.fl   = (!m.res && m.flash_left > 0) ? 1 : 0;
      if (m.res)      e.leds = (v[m.sel] > ledmax) ? ledmax : v[m.sel];
      else if (e.fl)  e.leds = ledmax;
      else            e.leds = 0;
   endfunction

   task automatic model_reset();
      ma = '{0, 0, 0, 0};
      mb = '{0, 0, 0, 0};
   endtask

   // Called just after a falling edge with inputs already driven.
   task automatic cyc();
      int   va[4];
      int   vb[4];
      exp_t ea, eb;
      @(posedge clk);
      for (int i = 0; i < N; i++) begin
         va[i] = int'(votes_a[i*8 +: 8]);
         vb[i] = int'(votes_b[i*10 +: 10]);
      end
      mstep(ma, va, 255, ea);
      mstep(mb, vb, 255, eb);
      qa.push_back(ea);
      qb.push_back(eb);
      @(negedge clk);
   endtask

   task automatic zero_chk(input string tag);
      chk({tag, "_leds_a"}, int'(leds_a), 0);
      chk({tag, "_sel_a"},  int'(sel_a),  0);
      chk({tag, "_win_a"},  int'(win_a),  0);
      chk({tag, "_tie_a"},  int'(tie_a),  0);
      chk({tag, "_fl_a"},   int'(fl_a),   0);
      chk({tag, "_leds_b"}, int'(leds_b), 0);
      chk({tag, "_sel_b"},  int'(sel_b),  0);
      chk({tag, "_win_b"},  int'(win_b),  0);
      chk({tag, "_tie_b"},  int'(tie_b),  0);
      chk({tag, "_fl_b"},   int'(fl_b),   0);
   endtask

   // Reset is raised mid-low-phase so the clear is visible before any edge.
   task automatic reset_async();
      #2 reset = 1'b1;
      #1 zero_chk("async_rst");
      mode  = 1'b0;
      valid = 1'b0;
      btn   = '0;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      model_reset();
   endtask

   task automatic check_one(input string p, input exp_t e, input int leds, input int sel,
                            input int win, input int tie, input int fl);
      chk({p, "_leds"},  leds, e.leds);
      chk({p, "_win"},   win,  e.win);
      chk({p, "_tie"},   tie,  e.tie);
      chk({p, "_flash"}, fl,   e.fl);
      if (e.res) chk({p, "_sel"}, sel, e.sel);
   endtask

   always @(negedge clk) begin : mon
      exp_t e;
      if (qa.size() > 0) begin
         e = qa.pop_front();
         check_one("a", e, int'(leds_a), int'(sel_a), int'(win_a), int'(tie_a), int'(fl_a));
      end
      if (qb.size() > 0) begin
         e = qb.pop_front();
         check_one("b", e, int'(leds_b), int'(sel_b), int'(win_b), int'(tie_b), int'(fl_b));
      end
   end

   initial begin
      model_reset();
      #1 reset = 1'b1;
      #2 zero_chk("reset");
      @(negedge clk);
      reset = 1'b0;

      // Single acknowledge, then a retrigger 6 cycles after a pulse
      valid = 1'b1; cyc(); valid = 1'b0;
      repeat (14) cyc();
      valid = 1'b1; cyc(); valid = 1'b0;
      repeat (5) cyc();
      valid = 1'b1; cyc(); valid = 1'b0;
      repeat (14) cyc();

      // Tied winner, mode entry, multi-button select; B exercises saturation
      votes_a = {8'd3, 8'd9, 8'd9, 8'd5};
      votes_b = {10'd0, 10'd0, 10'd200, 10'd300};
      cyc();
      mode = 1'b1;
      repeat (3) cyc();
      btn = 4'b1010;
      repeat (2) cyc();
      btn = 4'b0000;
      valid = 1'b1; cyc(); valid = 1'b0;
      repeat (3) cyc();

      // Back to vote mode, then vote and mode entry together; idle auto-scan
      mode = 1'b0;
      cyc();
      votes_a = '0;
      votes_b = '0;
      mode  = 1'b1;
      valid = 1'b1; cyc(); valid = 1'b0;
      repeat (120) cyc();
      btn = 4'b0100; cyc(); btn = 4'b0000;
      repeat (130) cyc();

      // Reset mid-scan, then mid-flash on its 4th cycle
      reset_async();
      repeat (5) cyc();
      valid = 1'b1; cyc(); valid = 1'b0;
      repeat (3) cyc();
      reset_async();
      repeat (15) cyc();

      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 149) == 0) mode = ~mode;
         valid = ($urandom_range(0, 7) == 0);
         btn   = ($urandom_range(0, 79) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
         if ($urandom_range(0, 3) == 0) begin
            for (int i = 0; i < N; i++) begin
               votes_a[i*8 +: 8]   = 8'($urandom_range(0, 6));
               votes_b[i*10 +: 10] = 10'($urandom_range(0, 400));
            end
         end
         if ($urandom_range(0, 599) == 0) reset_async();
         else                             cyc();
      end

      #1;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
